// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges redirect, execute stall, load-use,
// fetch-wait and interrupt entry into per-stage hold/flush/load controls.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_busy_i,
  input  logic        load_use_i,
  input  logic        bus_wait_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  output logic        pc_hold_o,
  output logic        pc_load_o,
  output logic [31:0] pc_addr_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_flush_o,
  output logic        int_ack_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_DRAIN = 2'd1,
    INT_JUMP  = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [31:0] vec_q, vec_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  logic        pc_hold, pc_load, if_id_hold, if_id_flush;
  logic        id_ex_hold, id_ex_flush, int_ack;
  logic [31:0] pc_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= 4'd0;
      vec_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    vec_d       = vec_q;
    pc_hold     = 1'b0;
    pc_load     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    int_ack     = 1'b0;
    pc_addr     = (state_q == RUN) ? jump_addr_i : vec_q;

    case (state_q)
      RUN: begin
        if (jump_flag_i) begin
          pc_load     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (div_busy_i) begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
        end else if (load_use_i) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end else if (int_req_i) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          vec_d       = int_addr_i;
          drain_d     = DRAIN_LOAD;
          state_d     = INT_DRAIN;
        end else if (bus_wait_i) begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
        end
      end
      INT_DRAIN: begin
        pc_hold     = 1'b1;
        if_id_flush = 1'b1;
        // A busy divider keeps its operands in ID/EX, so the bubble is
        // replaced by a hold and the drain count pauses.
        if (div_busy_i) begin
          id_ex_hold = 1'b1;
        end else begin
          id_ex_flush = 1'b1;
          if (drain_q == 4'd0) state_d = INT_JUMP;
          else                 drain_d = drain_q - 4'd1;
        end
      end
      INT_JUMP: begin
        pc_load     = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        int_ack     = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset masks the combinational controls so nothing moves while rst is high.
  assign pc_hold_o     = pc_hold & ~rst;
  assign pc_load_o     = pc_load & ~rst;
  assign if_id_hold_o  = if_id_hold & ~rst;
  assign if_id_flush_o = if_id_flush & ~rst;
  assign id_ex_hold_o  = id_ex_hold & ~rst;
  assign id_ex_flush_o = id_ex_flush & ~rst;
  assign int_ack_o     = int_ack & ~rst;
  assign pc_addr_o     = rst ? 32'd0 : pc_addr;
  assign state_o       = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_hold_o)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
